// File: rtl/mask_row_serializer.sv
// Captures one COLS-bit mask row per rp handshake and streams it out as LANE_W-bit beats.
// Define MASK_DBUF_EN to add a shadow row register so rows stream back-to-back with no bubble.
module mask_row_serializer #(
  parameter int COLS   = 640,
  parameter int LANE_W = 32,
  parameter int ROWS   = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     frame_start,
  input  logic [0:COLS-1]          mg_mask,
  input  logic                     rp_valid,
  output logic                     rp_ready,
  output logic [LANE_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(ROWS)-1:0]  row_addr,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int BEATS = COLS / LANE_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = $clog2(ROWS);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ROW  = 2'd1;
  localparam logic [1:0] S_SEND      = 2'd2;
  localparam logic [1:0] S_FRAME_END = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [RW-1:0]     row_q, row_d;
  logic [0:COLS-1]   buf_q, buf_d;
  logic [LANE_W-1:0] lanes [BEATS];
  logic              rp_hs, out_hs, last_beat;

`ifdef MASK_DBUF_EN
  logic [0:COLS-1]   shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
`endif

  // Pixel p of the row sits at bit (p % LANE_W) of beat (p / LANE_W).
  for (genvar b = 0; b < BEATS; b++) begin : g_lane
    for (genvar i = 0; i < LANE_W; i++) begin : g_bit
      assign lanes[b][i] = buf_q[b*LANE_W + i];
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign out_valid  = clk_en & (state_q == S_SEND);
  assign last_beat  = (beat_q == LAST_BEAT);
  assign out_last   = out_valid & last_beat;
  assign out_data   = lanes[beat_q];
  assign row_addr   = row_q;
  assign frame_done = clk_en & (state_q == S_FRAME_END);

`ifdef MASK_DBUF_EN
  // The shadow may only fill with a row that still belongs to this frame.
  assign rp_ready = clk_en & ((state_q == S_WAIT_ROW) |
                              ((state_q == S_SEND) & ~shadow_full_q & (row_q != LAST_ROW)));
`else
  assign rp_ready = clk_en & (state_q == S_WAIT_ROW);
`endif

  assign rp_hs  = rp_valid & rp_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    buf_d   = buf_q;
`ifdef MASK_DBUF_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          row_d   = '0;
          beat_d  = '0;
          state_d = S_WAIT_ROW;
        end
      end
      S_WAIT_ROW: begin
        if (rp_hs) begin
          buf_d   = mg_mask;
          beat_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
`ifdef MASK_DBUF_EN
        if (rp_hs) begin
          shadow_d      = mg_mask;
          shadow_full_d = 1'b1;
        end
`endif
        if (out_hs) begin
          if (!last_beat) begin
            beat_d = beat_q + BW'(1);
          end else begin
            beat_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = S_FRAME_END;
            end else begin
              row_d = row_q + RW'(1);
`ifdef MASK_DBUF_EN
              // A row arriving on the last-beat cycle goes straight to the main buffer.
              if (shadow_full_q) begin
                buf_d         = shadow_q;
                shadow_full_d = 1'b0;
              end else if (rp_hs) begin
                buf_d         = mg_mask;
                shadow_full_d = 1'b0;
              end else begin
                state_d = S_WAIT_ROW;
              end
`else
              state_d = S_WAIT_ROW;
`endif
            end
          end
        end
      end
      S_FRAME_END: begin
        state_d = S_IDLE;
`ifdef MASK_DBUF_EN
        shadow_full_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      buf_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
    end
  end

`ifdef MASK_DBUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else if (clk_en) begin
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
    end
  end
`endif

endmodule

// File: doc/mask_row_serializer.md
Name: mask_row_serializer

Overview:
- Downstream consumer of the mask generation stage.
- Captures one full 640-bit mask row (mg_mask) per rp_valid/rp_ready handshake.
- Streams the row to the pixel-array mask loader as LANE_W-bit beats, with a valid/ready handshake, row addressing and frame sequencing.
- Sits between mask generation and the sensor mask-load interface.

Parameters:
- COLS, 640, mask row width in pixels; must be an integer multiple of LANE_W.
- LANE_W, 32, bits per output beat; BEATS = COLS/LANE_W (20 at defaults).
- ROWS, 480, rows per frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active low
- clk_en  input  1  clock enable; when 0, no register updates
- frame_start  input  1  single-cycle pulse that arms a new frame
- mg_mask  input  [0:COLS-1]  mask row from mask generation; bit 0 = pixel 0
- rp_valid  input  1  mg_mask is valid
- rp_ready  output  1  block accepts a row this cycle
- out_data  output  LANE_W  beat data
- out_valid  output  1  beat valid
- out_ready  input  1  downstream accepts the beat
- out_last  output  1  current beat is the last beat of the row
- row_addr  output  clog2(ROWS)  row index of the row being sent
- frame_done  output  1  one-cycle pulse after the last row completes
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0. State = IDLE; beat_cnt, row_cnt and the row buffer cleared.
- FSM states: IDLE, WAIT_ROW, SEND, FRAME_END.
- IDLE:
  - frame_start=1 -> row_cnt=0, go to WAIT_ROW.
  - rp_valid is ignored (rp_ready=0).
- WAIT_ROW:
  - rp_ready=1.
  - On rp_valid: buffer <= mg_mask, beat_cnt=0, go to SEND.
- SEND:
  - out_valid=1.
  - out_data[i] = buffer[beat_cnt*LANE_W + i] for i = 0..LANE_W-1, so pixel 0 lands on out_data[0].
  - out_data is a mux of registered state; it is held stable while out_valid=1 and out_ready=0.
  - out_last = (beat_cnt == BEATS-1).
  - On each handshake (out_valid & out_ready): beat_cnt++.
  - On the handshake of the last beat:
    - row_cnt == ROWS-1 -> go to FRAME_END.
    - otherwise row_cnt++, go to WAIT_ROW.
- FRAME_END:
  - frame_done=1 for exactly one cycle, then go to IDLE.
- Timing:
  - Row captured in cycle N -> first beat valid in cycle N+1.
  - Row-to-row gap is 1 cycle with out_valid=0 (the WAIT_ROW capture cycle), provided rp_valid is already high.
- row_addr = row_cnt; stable for the whole row.
- clk_en=0:
  - All registers hold.
  - rp_ready and out_valid are forced to 0, so no handshake can complete.
  - Operation resumes at the same beat when clk_en returns to 1.
- frame_start while not in IDLE: ignored.
- Asynchronous reset mid-frame: immediate return to reset values; the partial row is discarded. The next frame_start begins at row 0, beat 0.
- Width rules: beat_cnt is clog2(BEATS) bits; row_cnt is clog2(ROWS) bits. Neither counter wraps; terminal compares are used.

Optional Feature:
- Macro: MASK_DBUF_EN (double buffering).
- With the macro defined:
  - A shadow row register and a shadow_full flag are added.
  - In SEND, rp_ready = !shadow_full; a handshake loads the shadow and sets shadow_full.
  - On the last-beat handshake with shadow_full=1 and row_cnt < ROWS-1: buffer <= shadow, clear shadow_full, row_cnt++, beat_cnt=0, remain in SEND. Beat 0 of the next row is presented the following cycle, with no bubble.
  - In WAIT_ROW, behaviour is as without the macro.
  - rp_ready=0 once the row with row_cnt=ROWS-1 is held in the buffer or shadow, so no extra row is accepted.
  - shadow_full clears on reset and on entry to IDLE.
- Without the macro: single buffer; rp_ready only in WAIT_ROW; 1-cycle row gap.

Test Plan:
- Beat mapping: frame_start; row with only mg_mask[0] and mg_mask[639] set; out_ready=1 -> beat0 out_data=32'h0000_0001, beats 1-18 = 0, beat19 out_data=32'h8000_0000 with out_last=1, row_addr=0.
- Backpressure: out_ready=0 for 5 cycles at beat 7 (row pattern 32'hA5A5A5A5 per lane) -> out_data stays 32'hA5A5A5A5, out_valid stays 1, beat 8 appears only after out_ready=1.
- Full frame at defaults, rp_valid and out_ready held 1 -> 9600 beats, 480 out_last pulses, row_addr steps 0..479, one frame_done pulse one cycle after the final handshake, then busy=0.
- clk_en=0 for 3 cycles at beat 12 -> out_valid=0 and rp_ready=0 during the stall, then beat 12 is re-presented with unchanged data; total beat count still 20.
- Reset: rst_n low at row 3, beat 10 -> all outputs 0 immediately; next frame_start yields row_addr=0, beat 0; a frame_start while busy=1 is ignored.
- MASK_DBUF_EN with rp_valid held 1:
  - Defined: out_last of row k is followed next cycle by row k+1 beat 0; a full frame takes 9600 out_valid cycles plus no gaps.
  - Not defined: exactly one out_valid=0 cycle between rows.
